// File: rtl/fp_mul_pipe.sv
// 3-stage pipelined floating-point multiplier (decode, multiply, normalise/round/pack), BF16 by default.
// Define FPMUL_FLAGS_EN to add the out_flags port {invalid, overflow, underflow, inexact}.
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_p
`ifdef FPMUL_FLAGS_EN
    ,
    output logic [3:0]   out_flags
`endif
);

    localparam int SIG_W  = MAN_W + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam int XE_W   = EXP_W + 2;
    localparam int BIAS   = (1 << (EXP_W - 1)) - 1;
    localparam logic [XE_W-1:0] BIAS_X = XE_W'(BIAS);
    localparam logic [XE_W-1:0] ONE_X  = XE_W'(1);
    localparam logic [XE_W-1:0] EMAX_X = XE_W'((1 << EXP_W) - 1);
    localparam logic [W-1:0]    QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // S1 decode
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_man, b_man;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    assign a_exp  = in_a[W-2 -: EXP_W];
    assign b_exp  = in_b[W-2 -: EXP_W];
    assign a_man  = in_a[MAN_W-1:0];
    assign b_man  = in_b[MAN_W-1:0];
    assign a_zero = (a_exp == '0);
    assign b_zero = (b_exp == '0);
    assign a_inf  = (&a_exp) && (a_man == '0);
    assign b_inf  = (&b_exp) && (b_man == '0);
    assign a_nan  = (&a_exp) && (a_man != '0);
    assign b_nan  = (&b_exp) && (b_man != '0);

    logic              s1_vld, s1_sign, s1_nan, s1_inf, s1_zero;
    logic [XE_W-1:0]   s1_esum;
    logic [SIG_W-1:0]  s1_sig_a, s1_sig_b;

    logic              s2_vld, s2_sign, s2_nan, s2_inf, s2_zero;
    logic [XE_W-1:0]   s2_esum;
    logic [PROD_W-1:0] s2_prod;

    // S3 normalise, round, pack
    logic [MAN_W-1:0]  n_man, r_man;
    logic              n_guard, n_sticky, round_up, r_carry;
    logic [XE_W-1:0]   n_exp, f_exp;
    logic              ovf, unf;
    logic [W-1:0]      res_p;
`ifdef FPMUL_FLAGS_EN
    logic [3:0]        res_f;
`endif

    always_comb begin
        n_man    = s2_prod[PROD_W-3 -: MAN_W];
        n_guard  = s2_prod[MAN_W-1];
        n_sticky = |s2_prod[MAN_W-2:0];
        n_exp    = s2_esum;
        if (s2_prod[PROD_W-1]) begin
            n_man    = s2_prod[PROD_W-2 -: MAN_W];
            n_guard  = s2_prod[MAN_W];
            n_sticky = |s2_prod[MAN_W-1:0];
            n_exp    = s2_esum + ONE_X;
        end
        // Ties go up only when the kept LSB is odd, giving round-half-even.
        round_up           = n_guard && (n_sticky || n_man[0]);
        {r_carry, r_man}   = {1'b0, n_man} + (MAN_W+1)'(round_up);
        f_exp              = n_exp + XE_W'(r_carry);
        unf                = f_exp[XE_W-1] || (f_exp == '0);
        ovf                = !f_exp[XE_W-1] && (f_exp >= EMAX_X);

        res_p = {s2_sign, f_exp[EXP_W-1:0], r_man};
`ifdef FPMUL_FLAGS_EN
        res_f = {3'b000, n_guard || n_sticky};
`endif
        if (s2_nan) begin
            res_p = QNAN;
`ifdef FPMUL_FLAGS_EN
            res_f = 4'b1000;
`endif
        end else if (s2_inf) begin
            res_p = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`ifdef FPMUL_FLAGS_EN
            res_f = 4'b0000;
`endif
        end else if (s2_zero) begin
            res_p = {s2_sign, {(W-1){1'b0}}};
`ifdef FPMUL_FLAGS_EN
            res_f = 4'b0000;
`endif
        end else if (ovf) begin
            res_p = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`ifdef FPMUL_FLAGS_EN
            res_f = 4'b0101;
`endif
        end else if (unf) begin
            res_p = {s2_sign, {(W-1){1'b0}}};
`ifdef FPMUL_FLAGS_EN
            res_f = 4'b0011;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld    <= 1'b0;
            s2_vld    <= 1'b0;
            out_valid <= 1'b0;
            out_p     <= '0;
`ifdef FPMUL_FLAGS_EN
            out_flags <= '0;
`endif
        end else if (adv) begin
            s1_vld    <= in_valid;
            s2_vld    <= s1_vld;
            out_valid <= s2_vld;
            if (s2_vld) begin
                out_p     <= res_p;
`ifdef FPMUL_FLAGS_EN
                out_flags <= res_f;
`endif
            end
        end
    end

    // Datapath registers carry no reset; their valid bits gate every use.
    always_ff @(posedge clk) begin
        if (adv) begin
            s1_sign  <= in_a[W-1] ^ in_b[W-1];
            s1_nan   <= a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf);
            s1_inf   <= a_inf || b_inf;
            s1_zero  <= a_zero || b_zero;
            s1_esum  <= {2'b00, a_exp} + {2'b00, b_exp} - BIAS_X;
            s1_sig_a <= {1'b1, a_man};
            s1_sig_b <= {1'b1, b_man};

            s2_sign  <= s1_sign;
            s2_nan   <= s1_nan;
            s2_inf   <= s1_inf;
            s2_zero  <= s1_zero;
            s2_esum  <= s1_esum;
            s2_prod  <= PROD_W'(s1_sig_a) * PROD_W'(s1_sig_b);
        end
    end

endmodule
